// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage program counter with branch select and return-address stack
// Next PC is chosen combinationally from redirect, stall, branch or sequential flow and registered each edge.
module pc_sequencer #(
   parameter int                ADDR_W    = 32,
   parameter int                STEP      = 4,
   parameter int                RAS_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          stall,
   input  logic                          redirect_valid,
   input  logic [ADDR_W-1:0]             redirect_pc,
   input  logic                          branch_valid,
   input  logic [2:0]                    branch_type,
   input  logic                          carry,
   input  logic                          zero,
   input  logic                          sign,
   input  logic [ADDR_W-1:0]             rs_val,
   input  logic [ADDR_W-1:0]             target,
   input  logic [ADDR_W-1:0]             offset,
   output logic [ADDR_W-1:0]             pc,
   output logic                          taken,
   output logic [$clog2(RAS_DEPTH):0]    ras_count,
   output logic                          ras_underflow
);

   localparam int                PW     = $clog2(RAS_DEPTH);
   localparam int                CW     = PW + 1;
   localparam logic [CW-1:0]     FULL   = CW'(RAS_DEPTH);
   localparam logic [ADDR_W-1:0] STEP_W = ADDR_W'(STEP);

   typedef enum logic [2:0] {
      BR_NONE = 3'b000,
      BR_JABS = 3'b001,
      BR_JREG = 3'b010,
      BR_BZ   = 3'b011,
      BR_BNZ  = 3'b100,
      BR_BCY  = 3'b101,
      BR_CALL = 3'b110,
      BR_RET  = 3'b111
   } br_t;

   logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
   logic [PW-1:0]     ras_ptr;
   logic [PW-1:0]     ptr_dec;
   logic [ADDR_W-1:0] seq_pc;
   logic [ADDR_W-1:0] rel_pc;
   logic [ADDR_W-1:0] pc_nxt;
   logic              taken_nxt;
   logic              uf_nxt;
   logic              do_push;
   logic              do_pop;
   logic              unused_sign;

   assign unused_sign = sign;
   assign seq_pc      = pc + STEP_W;
   assign rel_pc      = seq_pc + offset;
   assign ptr_dec     = ras_ptr - PW'(1);

   always_comb begin
      pc_nxt    = seq_pc;
      taken_nxt = 1'b0;
      uf_nxt    = 1'b0;
      do_push   = 1'b0;
      do_pop    = 1'b0;
      if (redirect_valid) begin
         pc_nxt    = redirect_pc;
         taken_nxt = 1'b1;
      end else if (stall) begin
         pc_nxt = pc;
      end else if (branch_valid) begin
         case (br_t'(branch_type))
            BR_JABS: begin pc_nxt = target; taken_nxt = 1'b1; end
            BR_JREG: begin pc_nxt = rs_val; taken_nxt = 1'b1; end
            BR_BZ:   if (zero)  begin pc_nxt = rel_pc; taken_nxt = 1'b1; end
            BR_BNZ:  if (!zero) begin pc_nxt = rel_pc; taken_nxt = 1'b1; end
            BR_BCY:  if (carry) begin pc_nxt = rel_pc; taken_nxt = 1'b1; end
            BR_CALL: begin
               pc_nxt    = target;
               taken_nxt = 1'b1;
               do_push   = 1'b1;
            end
            BR_RET: begin
               // An empty stack falls through sequentially and only flags the underflow.
               if (ras_count == '0) begin
                  uf_nxt = 1'b1;
               end else begin
                  pc_nxt    = ras_mem[ptr_dec];
                  taken_nxt = 1'b1;
                  do_pop    = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc            <= RESET_PC;
         taken         <= 1'b0;
         ras_underflow <= 1'b0;
         ras_ptr       <= '0;
         ras_count     <= '0;
      end else begin
         pc            <= pc_nxt;
         taken         <= taken_nxt;
         ras_underflow <= uf_nxt;
         if (do_push) begin
            ras_ptr <= ras_ptr + PW'(1);
            if (ras_count != FULL) ras_count <= ras_count + CW'(1);
         end else if (do_pop) begin
            ras_ptr   <= ptr_dec;
            ras_count <= ras_count - CW'(1);
         end
      end
   end

   // Stack contents need no reset; a full push simply overwrites the oldest slot.
   always_ff @(posedge clk) begin
      if (!rst && do_push) ras_mem[ras_ptr] <= seq_pc;
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer against a queue-based reference model
// Driver pushes model predictions per edge; monitor pops and compares one cycle later.
module tb_pc_sequencer;

   localparam logic [31:0] RPC = 32'h100;
   localparam int          DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst, stall, redirect_valid, branch_valid, carry, zero, sign;
   logic [31:0] redirect_pc, rs_val, target, offset;
   logic [2:0]  branch_type;
   logic [31:0] pc;
   logic        taken, ras_underflow;
   logic [2:0]  ras_count;

   typedef struct {
      logic [31:0] pc;
      logic        taken;
      logic [2:0]  cnt;
      logic        uf;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mpc;
   logic [31:0] mras[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   pc_sequencer #(.ADDR_W(32), .STEP(4), .RAS_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .branch_valid(branch_valid), .branch_type(branch_type),
      .carry(carry), .zero(zero), .sign(sign), .rs_val(rs_val), .target(target),
      .offset(offset), .pc(pc), .taken(taken), .ras_count(ras_count),
      .ras_underflow(ras_underflow)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain arithmetic on the current inputs, RAS as a bounded queue.
   task automatic tick();
      exp_t        e;
      logic [31:0] seq;
      e.taken = 1'b0;
      e.uf    = 1'b0;
      if (rst) begin
         mpc = RPC;
         mras.delete();
      end else if (redirect_valid) begin
         mpc     = redirect_pc;
         e.taken = 1'b1;
      end else if (!stall) begin
         seq = mpc + 32'd4;
         mpc = seq;
         if (branch_valid) begin
            case (branch_type)
               3'd1: begin mpc = target; e.taken = 1'b1; end
               3'd2: begin mpc = rs_val; e.taken = 1'b1; end
               3'd3: if (zero)  begin mpc = seq + offset; e.taken = 1'b1; end
               3'd4: if (!zero) begin mpc = seq + offset; e.taken = 1'b1; end
               3'd5: if (carry) begin mpc = seq + offset; e.taken = 1'b1; end
               3'd6: begin
                  mras.push_back(seq);
                  if (mras.size() > DEPTH) void'(mras.pop_front());
                  mpc = target; e.taken = 1'b1;
               end
               3'd7: if (mras.size() > 0) begin
                  mpc = mras.pop_back(); e.taken = 1'b1;
               end else e.uf = 1'b1;
               default: ;
            endcase
         end
      end
      e.pc  = mpc;
      e.cnt = 3'(mras.size());
      sb.push_back(e);
      @(negedge clk);
   endtask

   task automatic clr();
      rst = 0; stall = 0; redirect_valid = 0; redirect_pc = 0; branch_valid = 0;
      branch_type = 0; carry = 0; zero = 0; sign = 0; rs_val = 0; target = 0; offset = 0;
   endtask

   task automatic seq_op();
      clr(); tick();
   endtask

   task automatic redir(input logic [31:0] a);
      clr(); redirect_valid = 1; redirect_pc = a; tick();
   endtask

   task automatic br(input logic [2:0] t, input logic [31:0] tg, input logic z);
      clr(); branch_valid = 1; branch_type = t; target = tg; zero = z; offset = 32'hFFFF_FFF0; tick();
   endtask

   task automatic do_reset();
      clr(); rst = 1; tick();
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pc", pc, e.pc);
            chk("taken", 32'(taken), 32'(e.taken));
            chk("ras_count", 32'(ras_count), 32'(e.cnt));
            chk("ras_underflow", 32'(ras_underflow), 32'(e.uf));
         end
      end
   end

   initial begin : driver
      clr();
      rst = 1;
      @(negedge clk);
      do_reset();
      repeat (3) seq_op();
      redir(32'h200); br(3'd3, 0, 1'b1);
      redir(32'h200); br(3'd3, 0, 1'b0);
      redir(32'h40); br(3'd6, 32'h800, 0); seq_op(); seq_op(); br(3'd7, 0, 0);
      do_reset(); redir(32'h0);
      for (int i = 0; i < 5; i++) br(3'd6, 32'(i + 1) << 8, 0);
      for (int i = 0; i < 5; i++) br(3'd7, 0, 0);
      repeat (2) begin clr(); stall = 1; branch_valid = 1; branch_type = 3'd1; target = 32'h999; tick(); end
      clr(); stall = 1; branch_valid = 1; branch_type = 3'd1; redirect_valid = 1; redirect_pc = 32'h80; tick();
      redir(32'hFFFF_FFFC); seq_op();
      br(3'd6, 32'h300, 0); clr(); rst = 1; branch_valid = 1; branch_type = 3'd6; tick();
      seq_op();
      for (int i = 0; i < 3000; i++) begin
         rst            = ($urandom_range(0, 199) == 0);
         redirect_valid = ($urandom_range(0, 15) == 0);
         stall          = ($urandom_range(0, 7) == 0);
         branch_valid   = ($urandom_range(0, 3) != 0);
         branch_type    = 3'($urandom);
         carry          = 1'($urandom);
         zero           = 1'($urandom);
         sign           = 1'($urandom);
         redirect_pc    = $urandom;
         rs_val         = $urandom;
         target         = $urandom;
         offset         = $urandom;
         tick();
      end
      clr();
      @(posedge clk); #2;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
